// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - three-requester write-back request bus for rf_wb_arbiter
interface rf_wb_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [2:0]              req_valid;
    logic [3*ADDR_WIDTH-1:0] req_addr;
    logic [3*DATA_WIDTH-1:0] req_data;
    logic [2:0]              req_ready;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write-back arbiter with reset-time clear sweep
// Optional RF_WB_ROUND_ROBIN_EN selects rotating priority; default is fixed 0 > 1 > 2.
module rf_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rf_wb_arbiter_if.slave        req,
    output logic                  rf_write_en,
    output logic [ADDR_WIDTH-1:0] rf_in_address,
    output logic [DATA_WIDTH-1:0] rf_data_in,
    output logic                  init_done
);
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [1:0]            base;
    logic [1:0]            sel_idx;
    logic                  any_grant;
    logic [2:0]            grant;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    int                    cand;

`ifdef RF_WB_ROUND_ROBIN_EN
    logic [1:0] rr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 2'd0;
        end else if (any_grant) begin
            rr_ptr <= (sel_idx == 2'd2) ? 2'd0 : sel_idx + 2'd1;
        end
    end

    assign base = rr_ptr;
`else
    assign base = 2'd0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (state == INIT && cnt == LAST_ADDR) begin
            state_next = RUN;
        end
    end

    // Search from the highest-priority requester; descending loop lets the nearest win.
    always_comb begin
        sel_idx   = 2'd0;
        any_grant = 1'b0;
        cand      = 0;
        if (state == RUN) begin
            for (int k = 2; k >= 0; k--) begin
                cand = (int'(base) + k) % 3;
                if (req.req_valid[cand]) begin
                    sel_idx   = 2'(cand);
                    any_grant = 1'b1;
                end
            end
        end
        grant = any_grant ? (3'b001 << sel_idx) : 3'b000;
    end

    assign req.req_ready = grant;
    assign sel_addr      = req.req_addr[int'(sel_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_data      = req.req_data[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign init_done     = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end else if (state == INIT && cnt != LAST_ADDR) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Outputs are registered so they are stable across the cycle for the falling-edge RF write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_write_en   <= 1'b0;
            rf_in_address <= '0;
            rf_data_in    <= '0;
        end else if (state == INIT) begin
            rf_write_en   <= 1'b1;
            rf_in_address <= cnt;
            rf_data_in    <= '0;
        end else if (any_grant) begin
            rf_write_en   <= (sel_addr != '0);
            rf_in_address <= sel_addr;
            rf_data_in    <= sel_data;
        end else begin
            rf_write_en   <= 1'b0;
        end
    end
endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of the write data path.
REQ-002 Parameter ADDR_WIDTH, default 5, width of the register address; register count is 2^ADDR_WIDTH.
REQ-003 CLK  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 REQ_VALID  input  3  per-requester write request; bit 0 is ALU, bit 1 is load unit, bit 2 is neuron-update unit.
REQ-006 REQ_ADDR  input  3*ADDR_WIDTH  destination register per requester; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-007 REQ_DATA  input  3*DATA_WIDTH  write data per requester, sliced the same way.
REQ-008 REQ_READY  output  3  one-hot grant; a handshake occurs when REQ_VALID[i] and REQ_READY[i] are both 1 at a rising edge.
REQ-009 RF_WRITE_EN  output  1  register-file write enable.
REQ-010 RF_IN_ADDRESS  output  ADDR_WIDTH  register-file write address.
REQ-011 RF_DATA_IN  output  DATA_WIDTH  register-file write data.
REQ-012 INIT_DONE  output  1  set once the register-clear sweep has completed.

Function
REQ-013 The FSM SHALL have two states: INIT and RUN.
REQ-014 INIT: a counter SHALL step through 1..(2^ADDR_WIDTH - 1), one value per cycle.
REQ-015 In each INIT cycle the block SHALL drive RF_WRITE_EN=1, RF_IN_ADDRESS=counter and RF_DATA_IN=0.
REQ-016 REQ_READY SHALL be 0 throughout INIT.
REQ-017 After the cycle that writes the last address, the FSM SHALL enter RUN and set INIT_DONE=1.
REQ-018 INIT SHALL last exactly 31 cycles at the default ADDR_WIDTH.
REQ-019 RUN: REQ_READY SHALL be combinational from REQ_VALID and arbiter state.
REQ-020 At most one REQ_READY bit SHALL be 1, and only for a requester whose REQ_VALID is 1.
REQ-021 A requester that is idle SHALL never be granted.
REQ-022 A handshake SHALL register that requester's address and data into RF_IN_ADDRESS and RF_DATA_IN at the same edge.
REQ-023 At that edge RF_WRITE_EN SHALL be set to 1 only if the address is non-zero.
REQ-024 Write latency SHALL be one cycle: outputs are valid for the whole following cycle, so the register file's falling-edge write captures them.
REQ-025 A handshake to address 0 SHALL be accepted (ready=1) but SHALL produce RF_WRITE_EN=0.
REQ-026 In a RUN cycle with no handshake, RF_WRITE_EN SHALL be 0, and RF_IN_ADDRESS and RF_DATA_IN SHALL hold their previous values.
REQ-027 Throughput SHALL be one write per cycle, with no bubble between back-to-back grants.
REQ-028 Simultaneous requests are resolved per REQ-035/REQ-036; requesters that lose SHALL see ready=0 and SHALL hold valid, address and data stable until granted.
REQ-029 Once in RUN, the FSM SHALL stay in RUN until reset.

Reset
REQ-030 While RESET=0, the FSM SHALL go asynchronously to INIT, with the counter at 1.
REQ-031 While RESET=0, the outputs SHALL be: INIT_DONE=0, RF_WRITE_EN=0, RF_IN_ADDRESS=0, RF_DATA_IN=0, REQ_READY=0.
REQ-032 On deassertion, the first rising edge SHALL begin the sweep at address 1.
REQ-033 Reset asserted mid-sweep or mid-RUN SHALL abort any in-flight write and restart the full sweep.
REQ-034 With the round-robin build (REQ-035), the round-robin pointer SHALL reset to requester 0 as the highest priority.

Configuration
REQ-035 With macro RF_WB_ROUND_ROBIN_EN defined, priority SHALL rotate: after a grant to requester i, requester (i+1) mod 3 becomes highest priority; the pointer is unchanged on cycles with no grant.
REQ-036 With RF_WB_ROUND_ROBIN_EN undefined, priority SHALL be fixed: 0 over 1 over 2, and no pointer register is built.

Verification
REQ-037 Reset release, no requests: RF_WRITE_EN=1 for 31 cycles with addresses 1..31 and data 0, then INIT_DONE=1 and RF_WRITE_EN=0.
REQ-038 Pulse RESET low at sweep address 10: outputs zero immediately; after release the sweep restarts at address 1 and INIT_DONE rises 31 cycles later.
REQ-039 In RUN, requester 1 writes address 7 with data 0xDEADBEEF: ready1=1 that cycle; next cycle RF_WRITE_EN=1, RF_IN_ADDRESS=7, RF_DATA_IN=0xDEADBEEF.
REQ-040 All three requesters valid for 6 cycles, round-robin build: grant order 0,1,2,0,1,2. Fixed-priority build: requester 0 granted every cycle.
REQ-041 Requester 2 writes address 0 with data 0x1234: ready2=1 and RF_WRITE_EN stays 0 in the next cycle.
REQ-042 Requester 0 issues 4 back-to-back writes to addresses 3,4,5,6: RF_WRITE_EN=1 on 4 consecutive cycles with matching addresses.
